// File: rtl/regfile_access_scheduler_if.sv
// Request/response bundle between an upstream requester and the register
// file access scheduler: a write channel, a dual-read channel and the
// fixed-latency read response.
interface regfile_access_scheduler_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [4:0]            wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  logic                  rd_valid;
  logic                  rd_ready;
  logic [4:0]            rd_addr1;
  logic [4:0]            rd_addr2;
  logic                  rd_en1;
  logic                  rd_en2;

  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data1;
  logic [DATA_WIDTH-1:0] rsp_data2;

  // Requester side.
  modport master (
    output wr_valid, wr_addr, wr_data,
    output rd_valid, rd_addr1, rd_addr2, rd_en1, rd_en2,
    input  wr_ready, rd_ready,
    input  rsp_valid, rsp_data1, rsp_data2
  );

  // Scheduler side.
  modport slave (
    input  wr_valid, wr_addr, wr_data,
    input  rd_valid, rd_addr1, rd_addr2, rd_en1, rd_en2,
    output wr_ready, rd_ready,
    output rsp_valid, rsp_data1, rsp_data2
  );
endinterface

// File: rtl/regfile_access_scheduler.sv
// Front-end for a 32-entry 2R/1W register file. Buffers one write and one
// dual-read request, issues them so a write never hits an address being read
// in the same cycle (the read wins, the write waits), and returns read data
// one cycle after issue, aligned to the file's registered outputs.
module regfile_access_scheduler #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_access_scheduler_if.slave req,
  output logic [DATA_WIDTH-1:0] rf_din,
  output logic [4:0]            rf_wad1,
  output logic [4:0]            rf_rad1,
  output logic [4:0]            rf_rad2,
  output logic                  rf_wen1,
  output logic                  rf_ren1,
  output logic                  rf_ren2,
  input  logic [DATA_WIDTH-1:0] rf_dout1,
  input  logic [DATA_WIDTH-1:0] rf_dout2,
  input  logic                  rf_collision,
  output logic [15:0]           conflict_cnt,
  output logic                  err_sticky
);

  // Holding registers: pend flags are reset, payload is not.
  logic                  wr_pend;
  logic [4:0]            wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  rd_pend;
  logic [4:0]            rd_addr1_q;
  logic [4:0]            rd_addr2_q;
  logic                  rd_en1_q;
  logic                  rd_en2_q;

  logic                  dup;
  logic                  dup_q;
  logic                  conf;
  logic                  wr_issue;
  logic                  rd_issue;
  logic                  wr_hs;
  logic                  rd_hs;
  logic                  rsp_valid_q;

  // Issue decisions, derived only from held state so ready never depends on valid.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path; here each is assigned unconditionally, so no latch can form.
    dup      = rd_en1_q & rd_en2_q & (rd_addr1_q == rd_addr2_q);
    conf     = rd_pend & wr_pend &
               ((rd_en1_q & (rd_addr1_q == wr_addr_q)) |
                (rd_en2_q & (rd_addr2_q == wr_addr_q)));
    rd_issue = rd_pend;
    wr_issue = wr_pend & ~conf;
    wr_hs    = req.wr_valid & req.wr_ready;
    rd_hs    = req.rd_valid & req.rd_ready;
  end

  assign req.wr_ready = ~wr_pend | wr_issue;
  assign req.rd_ready = ~rd_pend | rd_issue;

  // Register file drive: held values while pending, zero otherwise.
  assign rf_wen1 = wr_issue;
  assign rf_wad1 = wr_pend ? wr_addr_q : 5'd0;
  assign rf_din  = wr_pend ? wr_data_q : '0;
  assign rf_ren1 = rd_pend & rd_en1_q;
  assign rf_ren2 = rd_pend & rd_en2_q & ~dup;
  assign rf_rad1 = rd_pend ? rd_addr1_q : 5'd0;
  assign rf_rad2 = rd_pend ? rd_addr2_q : 5'd0;

  // Response: the file's outputs are already registered, so data passes straight through.
  assign req.rsp_valid = rsp_valid_q;
  assign req.rsp_data1 = rf_dout1;
  assign req.rsp_data2 = dup_q ? rf_dout1 : rf_dout2;

  // Pending flags: a handshake sets pend (even while the old entry issues), an issue alone clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_pend <= 1'b0;
      rd_pend <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      if (wr_hs)         wr_pend <= 1'b1;
      else if (wr_issue) wr_pend <= 1'b0;
      if (rd_hs)         rd_pend <= 1'b1;
      else if (rd_issue) rd_pend <= 1'b0;
    end
  end

  // Request payload capture on handshake.
  // NOTE: payload registers carry no reset; every use is gated by a pend flag that is reset, so their contents never matter while idle.
  always_ff @(posedge clk) begin
    if (wr_hs) begin
      wr_addr_q <= req.wr_addr;
      wr_data_q <= req.wr_data;
    end
    if (rd_hs) begin
      rd_addr1_q <= req.rd_addr1;
      rd_addr2_q <= req.rd_addr2;
      rd_en1_q   <= req.rd_en1;
      rd_en2_q   <= req.rd_en2;
    end
  end

  // Response valid and duplicate-address flag, one cycle behind the read issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      dup_q       <= 1'b0;
    end else begin
      rsp_valid_q <= rd_issue;
      dup_q       <= rd_issue & dup;
    end
  end

  // Saturating count of cycles in which the write was held back by a read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_cnt <= 16'd0;
    end else if (conf && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  // Sticky record of any collision reported by the file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_sticky <= 1'b0;
    end else if (rf_collision) begin
      err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_access_scheduler.sv
// Directed bench for regfile_access_scheduler with a behavioural 32x16
// register file (registered outputs, unread ports return 0, collision flag).
module tb_regfile_access_scheduler;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          force_coll;
  logic [DW-1:0] rf_din;
  logic [4:0]    rf_wad1, rf_rad1, rf_rad2;
  logic          rf_wen1, rf_ren1, rf_ren2;
  logic [DW-1:0] rf_dout1, rf_dout2;
  logic          coll_q;
  logic          rf_collision;
  logic [15:0]   conflict_cnt;
  logic          err_sticky;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_access_scheduler_if #(.DATA_WIDTH(DW)) bus ();

  regfile_access_scheduler #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (bus),
    .rf_din       (rf_din),
    .rf_wad1      (rf_wad1),
    .rf_rad1      (rf_rad1),
    .rf_rad2      (rf_rad2),
    .rf_wen1      (rf_wen1),
    .rf_ren1      (rf_ren1),
    .rf_ren2      (rf_ren2),
    .rf_dout1     (rf_dout1),
    .rf_dout2     (rf_dout2),
    .rf_collision (rf_collision),
    .conflict_cnt (conflict_cnt),
    .err_sticky   (err_sticky)
  );

  always #5 clk = ~clk;

  // Register file model, reset from the same source with inverted polarity.
  logic [DW-1:0] mem [32];
  logic          resetn;
  assign resetn       = ~reset;
  assign rf_collision = coll_q | force_coll;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rf_dout1 <= '0;
      rf_dout2 <= '0;
      coll_q   <= 1'b0;
    end else begin
      if (rf_wen1) mem[rf_wad1] <= rf_din;
      rf_dout1 <= rf_ren1 ? mem[rf_rad1] : '0;
      rf_dout2 <= rf_ren2 ? mem[rf_rad2] : '0;
      coll_q   <= rf_wen1 & ((rf_ren1 & (rf_rad1 == rf_wad1)) |
                             (rf_ren2 & (rf_rad2 == rf_wad1)));
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a write, wait (bounded) for ready, complete the handshake edge.
  task automatic do_write(input logic [4:0] a, input logic [DW-1:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    for (int i = 0; i < 20 && !bus.wr_ready; i++) step();
    check("wr_handshake", {31'd0, bus.wr_ready}, 32'd1);
    step();
    bus.wr_valid = 1'b0;
  endtask

  // Present a read, check port enables at issue and the response two edges later.
  task automatic do_read(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                         input logic e1, input logic e2,
                         input logic [DW-1:0] exp1, input logic [DW-1:0] exp2);
    bus.rd_valid = 1'b1;
    bus.rd_addr1 = a1;
    bus.rd_addr2 = a2;
    bus.rd_en1   = e1;
    bus.rd_en2   = e2;
    for (int i = 0; i < 20 && !bus.rd_ready; i++) step();
    check({tag, "_handshake"}, {31'd0, bus.rd_ready}, 32'd1);
    step();
    bus.rd_valid = 1'b0;
    check({tag, "_ren1"}, {31'd0, rf_ren1}, {31'd0, e1});
    check({tag, "_ren2"}, {31'd0, rf_ren2}, {31'd0, e2 & ~(e1 & (a1 == a2))});
    check({tag, "_rsp_early"}, {31'd0, bus.rsp_valid}, 32'd0);
    step();
    check({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
    check({tag, "_data1"}, {16'd0, bus.rsp_data1}, {16'd0, exp1});
    check({tag, "_data2"}, {16'd0, bus.rsp_data2}, {16'd0, exp2});
    step();
    check({tag, "_rsp_done"}, {31'd0, bus.rsp_valid}, 32'd0);
  endtask

  logic [DW-1:0] stream_exp [8];

  initial begin
    reset        = 1'b1;
    force_coll   = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rd_valid = 1'b0;
    bus.rd_addr1 = '0;
    bus.rd_addr2 = '0;
    bus.rd_en1   = 1'b0;
    bus.rd_en2   = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    check("rst_wr_ready", {31'd0, bus.wr_ready}, 32'd1);
    check("rst_rd_ready", {31'd0, bus.rd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rf_en", {29'd0, rf_wen1, rf_ren1, rf_ren2}, 32'd0);
    check("rst_rf_addr", {17'd0, rf_wad1, rf_rad1, rf_rad2}, 32'd0);
    check("rst_rf_din", {16'd0, rf_din}, 32'd0);
    check("rst_cnt", {16'd0, conflict_cnt}, 32'd0);
    check("rst_err", {31'd0, err_sticky}, 32'd0);
    check("rst_rsp_data", {bus.rsp_data1, bus.rsp_data2}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // Simple write then read.
    do_write(5'd3, 16'hBEEF);
    check("t1_wen", {31'd0, rf_wen1}, 32'd1);
    check("t1_wad", {27'd0, rf_wad1}, 32'd3);
    check("t1_din", {16'd0, rf_din}, 32'h0000BEEF);
    step();
    check("t1_wen_pulse", {31'd0, rf_wen1}, 32'd0);
    do_read("t1", 5'd3, 5'd0, 1'b1, 1'b0, 16'hBEEF, 16'h0000);
    check("t1_cnt", {16'd0, conflict_cnt}, 32'd0);

    // Write and read of the same address accepted together: read wins.
    do_write(5'd5, 16'h0001);
    step();
    bus.wr_valid = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 16'h1234;
    bus.rd_valid = 1'b1; bus.rd_addr1 = 5'd5; bus.rd_addr2 = 5'd0;
    bus.rd_en1 = 1'b1; bus.rd_en2 = 1'b0;
    check("t2_both_ready", {30'd0, bus.wr_ready, bus.rd_ready}, 32'd3);
    step();
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b0;
    check("t2_defer_wen", {31'd0, rf_wen1}, 32'd0);
    check("t2_read_first", {31'd0, rf_ren1}, 32'd1);
    check("t2_wr_ready_low", {31'd0, bus.wr_ready}, 32'd0);
    step();
    check("t2_wen_next", {31'd0, rf_wen1}, 32'd1);
    check("t2_cnt", {16'd0, conflict_cnt}, 32'd1);
    check("t2_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check("t2_old_data", {16'd0, bus.rsp_data1}, 32'h00000001);
    step();
    do_read("t2_new", 5'd5, 5'd0, 1'b1, 1'b0, 16'h1234, 16'h0000);

    // Duplicate read address: second port suppressed, data mirrored.
    do_write(5'd7, 16'h00AA);
    step();
    do_read("t3_dup", 5'd7, 5'd7, 1'b1, 1'b1, 16'h00AA, 16'h00AA);
    do_read("t3_none", 5'd7, 5'd7, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // Streaming: 8 reads (addr k) and 8 writes (addr 16+k) with valids held high.
    for (int k = 0; k < 8; k++) stream_exp[k] = 16'h0000;
    stream_exp[3] = 16'hBEEF;
    stream_exp[5] = 16'h1234;
    stream_exp[7] = 16'h00AA;
    for (int c = 0; c < 9; c++) begin
      if (c < 8) begin
        bus.wr_valid = 1'b1; bus.wr_addr = 5'(16 + c); bus.wr_data = 16'h1000 + 16'(c);
        bus.rd_valid = 1'b1; bus.rd_addr1 = 5'(c); bus.rd_addr2 = 5'd0;
        bus.rd_en1 = 1'b1; bus.rd_en2 = 1'b0;
        check("t4_readies", {30'd0, bus.wr_ready, bus.rd_ready}, 32'd3);
      end else begin
        bus.wr_valid = 1'b0;
        bus.rd_valid = 1'b0;
      end
      step();
      if (c >= 1) begin
        check("t4_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("t4_rsp_data", {16'd0, bus.rsp_data1}, {16'd0, stream_exp[c-1]});
      end
    end
    step();
    check("t4_rsp_end", {31'd0, bus.rsp_valid}, 32'd0);
    do_read("t4_wr_landed", 5'd23, 5'd0, 1'b1, 1'b0, 16'h1007, 16'h0000);
    check("t4_err", {31'd0, err_sticky}, 32'd0);

    // Reset with a write pending and a response in flight.
    bus.wr_valid = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 16'h5555;
    bus.rd_valid = 1'b1; bus.rd_addr1 = 5'd9; bus.rd_en1 = 1'b1; bus.rd_en2 = 1'b0;
    check("t5_ready", {30'd0, bus.wr_ready, bus.rd_ready}, 32'd3);
    step();
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b0;
    step();
    check("t5_pre_rsp", {31'd0, bus.rsp_valid}, 32'd1);
    check("t5_pre_wen", {31'd0, rf_wen1}, 32'd1);
    reset = 1'b1;
    #1;
    check("t5_rsp_drop", {31'd0, bus.rsp_valid}, 32'd0);
    check("t5_readies", {30'd0, bus.wr_ready, bus.rd_ready}, 32'd3);
    check("t5_wen_rst", {31'd0, rf_wen1}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_no_wen", {31'd0, rf_wen1}, 32'd0);
    end
    check("t5_cnt", {16'd0, conflict_cnt}, 32'd0);
    do_read("t5_discarded", 5'd9, 5'd0, 1'b1, 1'b0, 16'h0000, 16'h0000);

    // Starve a write with same-address reads: counter exact, then saturating.
    bus.wr_valid = 1'b1; bus.wr_addr = 5'd10; bus.wr_data = 16'h7777;
    bus.rd_valid = 1'b1; bus.rd_addr1 = 5'd10; bus.rd_en1 = 1'b1; bus.rd_en2 = 1'b0;
    check("t6_ready", {30'd0, bus.wr_ready, bus.rd_ready}, 32'd3);
    step();
    bus.wr_valid = 1'b0;
    repeat (100) step();
    check("t6_cnt_100", {16'd0, conflict_cnt}, 32'd100);
    check("t6_starved", {31'd0, bus.wr_ready}, 32'd0);
    repeat (69900) step();
    check("t6_cnt_sat", {16'd0, conflict_cnt}, 32'h0000FFFF);
    bus.rd_valid = 1'b0;
    step();
    check("t6_wen_release", {31'd0, rf_wen1}, 32'd1);
    check("t6_wad", {27'd0, rf_wad1}, 32'd10);
    check("t6_cnt_hold", {16'd0, conflict_cnt}, 32'h0000FFFF);
    step();
    do_read("t6_after", 5'd10, 5'd0, 1'b1, 1'b0, 16'h7777, 16'h0000);
    check("t6_no_coll", {31'd0, err_sticky}, 32'd0);

    // Injected collision: sticky until reset.
    force_coll = 1'b1;
    step();
    force_coll = 1'b0;
    check("t7_err_set", {31'd0, err_sticky}, 32'd1);
    repeat (5) step();
    check("t7_err_hold", {31'd0, err_sticky}, 32'd1);
    reset = 1'b1;
    #1;
    check("t7_err_clear", {31'd0, err_sticky}, 32'd0);
    check("t7_cnt_clear", {16'd0, conflict_cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_access_scheduler.md
# regfile_access_scheduler

Request front-end for the 32-entry, 2-read/1-write register file. Accepts independent write and dual-read requests over valid/ready channels and buffers one of each. It issues them to the register file ports so that the file's collision condition never occurs, splitting a conflicting write from a read across cycles. It returns read data on a fixed-latency response channel aligned to the file's registered outputs.

## Interface
- DATA_WIDTH, 16, data width; must match the register file.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  write request accepted when high with wr_valid.
- wr_addr  in  5  write address.
- wr_data  in  DATA_WIDTH  write data.
- rd_valid  in  1  read request valid.
- rd_ready  out  1  read request accepted when high with rd_valid.
- rd_addr1, rd_addr2  in  5 each  read addresses.
- rd_en1, rd_en2  in  1 each  per-port read enables.
- rf_din  out  DATA_WIDTH  to register file din.
- rf_wad1  out  5  to register file wad1.
- rf_rad1, rf_rad2  out  5 each  to register file rad1/rad2.
- rf_wen1, rf_ren1, rf_ren2  out  1 each  to register file enables.
- rf_dout1, rf_dout2  in  DATA_WIDTH each  registered read data from the file.
- rf_collision  in  1  registered collision flag from the file.
- rsp_valid  out  1  read response valid; no backpressure.
- rsp_data1, rsp_data2  out  DATA_WIDTH each  read response data.
- conflict_cnt  out  16  count of write deferrals, saturating.
- err_sticky  out  1  set if rf_collision is ever observed high.

## Operation
- Holding registers, one per channel, with flags wr_pend and rd_pend.
- Channel handshake:
  - wr_ready = ~wr_pend | wr_issue; rd_ready = ~rd_pend | rd_issue.
  - No combinational path from valid to ready.
  - A handshake loads the holding register and sets pend. If the same cycle issues, pend stays set with the new contents.
- Read port enables:
  - dup = rd_en1 & rd_en2 & (rd_addr1 == rd_addr2), evaluated on held values.
  - rf_ren1 = rd_pend & rd_en1.
  - rf_ren2 = rd_pend & rd_en2 & ~dup.
- Read issue: rd_issue = rd_pend.
- Write conflict: conf = rd_pend & wr_pend & ((rd_en1 & rd_addr1 == wr_addr) | (rd_en2 & rd_addr2 == wr_addr)).
- Write issue: wr_issue = wr_pend & ~conf. rf_wen1 = wr_issue. Read wins; the write is deferred at least one cycle.
- conflict_cnt increments each cycle conf is 1 and saturates at 0xFFFF.
- rf_* address/data outputs drive the held values, or 0 when the matching pend is 0.
- Response:
  - rsp_valid is set in the cycle after any read issue.
  - rsp_data1 = rf_dout1.
  - rsp_data2 = rf_dout1 if the registered dup flag is set, else rf_dout2.
  - Disabled ports return 0, as the file zeroes unread outputs.
  - A read with both enables low still issues and produces rsp_valid with zero data.
- Ordering: responses arrive in read-acceptance order. A write issued in cycle N is visible to a read issued in N+1 or later.
- err_sticky sets on rf_collision = 1 and clears only on reset. In correct operation it never sets.

## Timing
- Reset (async assert, sync-safe deassert):
  - wr_pend, rd_pend, rsp_valid, the dup register, conflict_cnt and err_sticky = 0.
  - All rf_* outputs = 0.
  - wr_ready = rd_ready = 1.
  - rsp_data follows the file outputs, which are 0 while the file is in reset.
- The file is reset from the same source with inverted polarity (resetn = ~reset) by the parent.
- Read latency: accept at edge E0, issue in cycle E0..E1, response valid in cycle E1..E2. Two edges from handshake to rsp_valid.
- Throughput: one read and one write per cycle when non-conflicting. A conflicting write costs exactly one extra cycle per conflicting read ahead of it.
- Back-to-back reads to the write's address starve the write. This is accepted; the upstream must not stream unbounded same-address reads.
- Reset mid-operation: held requests and any in-flight response are discarded; rsp_valid drops immediately.

## Test plan
- Reset, then write addr 3 = 0xBEEF, then read en1 addr 3: rf_wen1 pulses one cycle and rsp_valid occurs 2 edges after the read handshake. Expect rsp_data1 = 0xBEEF, rsp_data2 = 0, conflict_cnt = 0.
- Write addr 5 = 0x1234 and read en1 addr 5 accepted on the same edge (addr 5 previously 0x0001): expect the read issued first with rsp_data1 = 0x0001, the write issued the next cycle, and conflict_cnt = 1. A following read of addr 5 returns 0x1234.
- Read en1 = en2 = 1, addr 7 = 7 (holding 0x00AA): expect rf_ren2 = 0 and rsp_data1 = rsp_data2 = 0x00AA.
- Stream 8 reads and 8 writes on disjoint addresses with both valids held high: expect wr_ready and rd_ready stay 1 and 8 responses arrive on consecutive cycles. rf_collision must stay 0 throughout and err_sticky must end 0.
- Assert reset with wr_pend = 1 and one response in flight: expect rsp_valid = 0 immediately, no rf_wen1 after deassert, and both readies = 1.
- Force 70000 conflicting cycles: expect conflict_cnt = 0xFFFF. Force rf_collision high for one cycle: expect err_sticky = 1 and held until reset.
